// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: pipelined WIDTH-bit add/subtract unit with a valid/ready handshake.
// The carry chain is cut into STAGES chunks of CW = WIDTH/STAGES bits. Stage k adds
// chunk k and registers the partial result, its carry-out and the operands that
// still have to be added, so the full result appears STAGES cycles after acceptance.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operation handshake (in_ready = ~out_valid | out_ready)
//   in_sub            0 = A+B, 1 = A-B
//   in_a, in_b        operands
//   in_tag            sideband tag carried with the operation
//   out_valid/out_ready result handshake
//   out_c, out_tag    result and the tag of the operation that produced it
//   out_zero, out_carry, out_ovf, out_neg  result flags
module alu_addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_neg
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Stage registers
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] r_q   [STAGES];
    logic             c_q   [STAGES];
    logic             z_q   [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic             ovf_q;

    // Per-stage inputs (from upstream) and next values
    logic             sv   [STAGES];
    logic [WIDTH-1:0] sa   [STAGES];
    logic [WIDTH-1:0] sb   [STAGES];
    logic [WIDTH-1:0] sr   [STAGES];
    logic             sc   [STAGES];
    logic             sz   [STAGES];
    logic [TAG_W-1:0] stag [STAGES];
    logic [CW:0]      sum_w [STAGES];
    logic [WIDTH-1:0] nr   [STAGES];
    logic             nz   [STAGES];
    logic             ovf_n;
    logic             en_c;

    // Whole pipe advances together; it stalls only when a finished result is not taken.
    assign en_c = ~v_q[LAST] | out_ready;

    // Stage inputs: stage 0 from the ports (B inverted for SUB, carry-in = in_sub), others from upstream.
    always_comb begin
        sv[0]   = in_valid;
        sa[0]   = in_a;
        sb[0]   = in_b ^ {WIDTH{in_sub}};
        sr[0]   = '0;
        sc[0]   = in_sub;
        sz[0]   = 1'b1;
        stag[0] = in_tag;
        for (int unsigned k = 1; k < STAGES; k++) begin
            sv[k]   = v_q[k-1];
            sa[k]   = a_q[k-1];
            sb[k]   = b_q[k-1];
            sr[k]   = r_q[k-1];
            sc[k]   = c_q[k-1];
            sz[k]   = z_q[k-1];
            stag[k] = tag_q[k-1];
        end
    end

    // Chunk adders; zero is accumulated chunk by chunk.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum_w[k] = {1'b0, sa[k][k*CW +: CW]} + {1'b0, sb[k][k*CW +: CW]} + (CW+1)'(sc[k]);
            nr[k]    = sr[k];
            nr[k][k*CW +: CW] = sum_w[k][CW-1:0];
            nz[k]    = sz[k] & (sum_w[k][CW-1:0] == '0);
        end
        // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
        ovf_n = sum_w[LAST][CW] ^ sa[LAST][WIDTH-1] ^ sb[LAST][WIDTH-1] ^ nr[LAST][WIDTH-1];
    end

    // Pipeline registers; data only loads with a valid op so outputs keep the last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                z_q[k]   <= 1'b0;
                tag_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en_c) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= sv[k];
                if (sv[k]) begin
                    a_q[k]   <= sa[k];
                    b_q[k]   <= sb[k];
                    r_q[k]   <= nr[k];
                    c_q[k]   <= sum_w[k][CW];
                    z_q[k]   <= nz[k];
                    tag_q[k] <= stag[k];
                end
            end
            if (sv[LAST]) begin
                ovf_q <= ovf_n;
            end
        end
    end

    assign in_ready  = en_c;
    assign out_valid = v_q[LAST];
    assign out_c     = r_q[LAST];
    assign out_tag   = tag_q[LAST];
    assign out_zero  = z_q[LAST];
    assign out_carry = c_q[LAST];
    assign out_ovf   = ovf_q;
    assign out_neg   = r_q[LAST][WIDTH-1];

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Self-checking bench for alu_addsub_pipe: directed vectors, streaming with a stall,
// mid-flight reset, and random sweeps over STAGES = 1, 2, 8, 32.
module tb_alu_addsub_pipe;

    localparam int NSW = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sub = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_c;
    logic [4:0]  out_tag;
    logic        out_zero, out_carry, out_ovf, out_neg;

    logic        sw_valid = 1'b0;
    logic        sw_sub = 1'b0;
    logic [31:0] sw_a = '0;
    logic [31:0] sw_b = '0;
    logic [4:0]  sw_tag = '0;

    logic [40:0] hist [1024];
    int          acc  [1024];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_addsub_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_tag(out_tag),
        .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf), .out_neg(out_neg)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {result, zero, carry, ovf, neg}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb;
        logic [32:0] s;
        logic        ovf;
        bb  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, bb} + 33'(sub);
        ovf = (a[31] == bb[31]) && (s[31] != a[31]);
        return {s[31:0], s[31:0] == 32'd0, s[32], ovf, s[31]};
    endfunction

    function automatic logic [35:0] obs();
        return {out_c, out_zero, out_carry, out_ovf, out_neg};
    endfunction

    // Random sweep instances; all share one stimulus stream with out_ready tied high.
    for (genvar g = 0; g < 4; g++) begin : sweep
        localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
        logic        ov, ir, oz, oy, oo, on;
        logic [31:0] oc;
        logic [4:0]  ot;
        int          rd = 0;

        alu_addsub_pipe #(.WIDTH(32), .STAGES(S), .TAG_W(5)) u (
            .clk(clk), .rst(rst),
            .in_valid(sw_valid), .in_ready(ir), .in_sub(sw_sub),
            .in_a(sw_a), .in_b(sw_b), .in_tag(sw_tag),
            .out_valid(ov), .out_ready(1'b1),
            .out_c(oc), .out_tag(ot),
            .out_zero(oz), .out_carry(oy), .out_ovf(oo), .out_neg(on)
        );

        always @(negedge clk) begin
            if (ov && rd < 1024) begin
                check($sformatf("sweep%0d_res", S), {ot, oc, oz, oy, oo, on}, hist[rd]);
                check($sformatf("sweep%0d_lat", S), cyc - acc[rd], S);
                check($sformatf("sweep%0d_rdy", S), ir, 1);
                rd++;
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [4:0] tag, input logic [35:0] exp, input string name);
        int lat;
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, "_lat"}, lat, 4);
        check(name, obs(), exp);
        check({name, "_tag"}, out_tag, tag);
    endtask

    initial begin
        logic [40:0] held;
        logic [40:0] e;
        logic [31:0] sa, sb;
        logic        ssub;
        logic        was_stall;
        int          rx, iss, seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", {out_tag, obs()}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 1);

        // Directed vectors
        run_op(32'h000000FF, 32'h00000001, 1'b0, 5'd1, {32'h00000100, 4'b0000}, "add_ff_1");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 5'd2, {32'h00000000, 4'b1100}, "add_wrap");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 5'd3, {32'h80000000, 4'b0011}, "add_ovf");
        run_op(32'h80000000, 32'h00000001, 1'b1, 5'd4, {32'h7FFFFFFF, 4'b0110}, "sub_ovf");
        run_op(32'h00000005, 32'h00000005, 1'b1, 5'd5, {32'h00000000, 4'b1100}, "sub_zero");
        run_op(32'h00000003, 32'h00000005, 1'b1, 5'd6, {32'hFFFFFFFE, 4'b0001}, "sub_neg");

        // Stream of 6 ops with a 3-cycle output stall
        rx = 0; iss = 0; was_stall = 1'b0; held = '0;
        for (int t = 0; t < 60 && rx < 6; t++) begin
            @(negedge clk);
            out_ready = !(t >= 6 && t <= 8);
            #1;
            check("stream_rdy", in_ready, !(out_valid && !out_ready));
            if (out_valid && !out_ready) begin
                if (was_stall) check("stall_hold", {out_tag, obs()}, held);
                held = {out_tag, obs()};
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                sa = 32'h10000000 * rx + 32'hFF;
                sb = 32'h00000101 * (rx + 1);
                e  = {5'(rx), model(sa, sb, rx[0])};
                check("stream_res", {out_tag, obs()}, e);
                rx++;
            end
            if (iss < 6) begin
                in_a = 32'h10000000 * iss + 32'hFF;
                in_b = 32'h00000101 * (iss + 1);
                in_sub = iss[0];
                in_tag = 5'(iss);
                in_valid = 1'b1;
                if (in_ready) iss++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("stream_cnt", rx, 6);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Reset with 3 ops in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_a = 32'h100 * (i + 1); in_b = 32'd7; in_sub = 1'b0;
            in_tag = 5'(20 + i); in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", {out_tag, obs()}, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_stale", seen, 0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 5'd9, {32'h23456789, 4'b0000}, "post_rst");

        // Random sweep across pipeline depths
        for (int n = 0; n < NSW; n++) begin
            @(negedge clk);
            sa   = $urandom;
            sb   = (n % 10 == 0) ? sa : $urandom;
            ssub = 1'($urandom_range(0, 1));
            if (n % 37 == 0) sa = 32'h7FFFFFFF;
            if (n % 41 == 0) sa = 32'h80000000;
            sw_a = sa; sw_b = sb; sw_sub = ssub; sw_tag = 5'(n);
            sw_valid = 1'b1;
            hist[n] = {5'(n), model(sa, sb, ssub)};
            acc[n]  = cyc;
        end
        @(negedge clk);
        sw_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("sweep1_cnt",  sweep[0].rd, NSW);
        check("sweep2_cnt",  sweep[1].rd, NSW);
        check("sweep8_cnt",  sweep[2].rd, NSW);
        check("sweep32_cnt", sweep[3].rd, NSW);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit combinational adder with zero flag.
- Splits a WIDTH-bit carry chain into STAGES registered chunks so the EX stage of the pipeline CPU can close timing at higher clock rates.
- Produces result plus zero/carry/overflow/negative flags, with a valid/ready handshake and a pass-through tag for instruction tracking.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; legal range 1..WIDTH.
- TAG_W, 5, width of sideband tag carried alongside each operation (e.g. destination register index).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  unit accepts operation this cycle.
- in_sub  in  1  0 = A+B, 1 = A-B.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result this cycle.
- out_c  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the operation that produced out_c.
- out_zero  out  1  out_c == 0.
- out_carry  out  1  unsigned carry out of MSB (for SUB: 1 = no borrow).
- out_ovf  out  1  signed two's-complement overflow.
- out_neg  out  1  out_c[WIDTH-1].

Behaviour:
- Clock/reset: one clock clk; rst synchronous, active-high. On a clk edge with rst=1, all stage valid bits clear and out_valid, out_c, out_tag and all flags are driven 0. in_ready=1 in the cycle after reset.
- Arithmetic:
  - SUB is A + ~B + 1; the carry-in of chunk 0 = in_sub.
  - Stage k (0..STAGES-1) adds chunk k of A and B' (B or ~B) plus the carry registered from stage k-1.
  - Stage k stores the sum chunk and carry-out. Lower result chunks and not-yet-added upper operand chunks are delayed alongside.
  - Result is modulo 2^WIDTH.
- Flags, computed from the final stage only:
  - carry = carry-out of the top chunk.
  - ovf = carry into MSB XOR carry out of MSB.
  - neg = out_c MSB.
  - zero = all result bits 0; it may be accumulated per chunk.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready at edge) to out_valid=1 when out_ready is held 1. STAGES=1 gives a single registered adder.
- Throughput: one operation per cycle with no stall; operations exit in acceptance order.
- Flow control:
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en.
  - When en=0 every stage register holds, including bubbles.
  - When en=1 every stage shifts one place; a stage loads valid=0 when its upstream was empty.
- Output stability: while out_valid=1 and out_ready=0, out_c, out_tag and all flags hold stable.
- Input handling: when in_valid=0 or in_ready=0 the inputs are ignored; no operation is lost or duplicated.
- Reset mid-operation: all in-flight operations are discarded; no stale result appears after reset deasserts.
- Output contents: out_c, out_tag and flags reflect the last valid operation when out_valid=0 (don't-care for the consumer), except after reset, when they are 0.

Test Plan:
- WIDTH=32, STAGES=4: ADD 0x000000FF + 0x00000001, out_ready=1 -> after 4 cycles out_c=0x00000100, zero=0, carry=0, ovf=0, neg=0 (carry crosses the chunk 0/1 boundary).
- ADD 0xFFFFFFFF + 0x00000001 -> out_c=0, zero=1, carry=1, ovf=0; ADD 0x7FFFFFFF + 1 -> 0x80000000, ovf=1, neg=1, carry=0.
- SUB 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf=1, carry=1, neg=0; SUB 5 - 5 -> 0, zero=1, carry=1; SUB 3 - 5 -> 0xFFFFFFFE, carry=0, neg=1.
- Stream 6 back-to-back ops, tags 0..5, with out_ready=0 for 3 cycles mid-stream -> in_ready=0 exactly while out_valid=1 and out_ready=0; outputs stable during the stall; all 6 results emerge in tag order with correct values.
- Assert rst for 1 cycle while 3 ops are in flight -> next cycle out_valid=0 and outputs 0; no results from those ops ever appear; a new op issued after reset completes in 4 cycles.
- Parameter sweep STAGES=1,2,8,32 with 1000 random A/B/in_sub values -> every result and flag matches a reference model; latency equals STAGES.
